// File: rtl/pc_sequencer.sv
// Architectural PC owner: issues fetch addresses over valid/ready, buffers one redirect, traps on misaligned targets.
// Optional `PC_SEQ_COMPRESSED_EN: 2-byte alignment and +2 increment when i_is_compressed is high at transfer.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_fetch_valid,
    input  logic        i_fetch_ready,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_pc_plus4,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    input  logic        i_stall,
    output logic        o_misalign_trap,
    output logic [31:0] o_trap_pc,
`ifdef PC_SEQ_COMPRESSED_EN
    input  logic        i_is_compressed,
`endif
    input  logic        i_trap_clear
);

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

`ifdef PC_SEQ_COMPRESSED_EN
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0001;
`else
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;
`endif

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pend_vld;
    logic [31:0] r_pend_tgt;
    logic [31:0] r_trap_pc;
    logic        r_hold;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_pend_vld_nxt;
    logic [31:0] w_pend_tgt_nxt;
    logic [31:0] w_trap_pc_nxt;
    logic        w_hold_nxt;
    logic        w_xfer;
    logic        w_have_tgt;
    logic [31:0] w_tgt;
    logic        w_misalign;
    logic [31:0] w_incr;

    assign o_fetch_pc      = r_pc;
    assign o_pc_plus4      = r_pc + 32'd4;
    assign o_misalign_trap = (r_state == TRAP);
    assign o_trap_pc       = r_trap_pc;
    // Once offered, a request is held regardless of stall until accepted.
    assign o_fetch_valid   = (r_state == RUN) && (!i_stall || r_hold);
    assign w_xfer          = o_fetch_valid && i_fetch_ready;

    // A live redirect beats a buffered one; both beat the sequential increment.
    assign w_have_tgt = i_redirect_valid || r_pend_vld;
    assign w_tgt      = i_redirect_valid ? i_redirect_target : r_pend_tgt;
    assign w_misalign = w_have_tgt && ((w_tgt & ALIGN_MASK) != 32'd0);

`ifdef PC_SEQ_COMPRESSED_EN
    assign w_incr = i_is_compressed ? 32'd2 : 32'd4;
`else
    assign w_incr = 32'd4;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_tgt_nxt = r_pend_tgt;
        w_trap_pc_nxt  = r_trap_pc;
        w_hold_nxt     = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
                if (i_redirect_valid) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_tgt_nxt = i_redirect_target;
                end
            end
            RUN: begin
                w_hold_nxt = o_fetch_valid && !i_fetch_ready;
                if (w_xfer) begin
                    w_pend_vld_nxt = 1'b0;
                    if (w_misalign) begin
                        w_state_nxt   = TRAP;
                        w_trap_pc_nxt = w_tgt;
                    end else if (w_have_tgt) begin
                        w_pc_nxt = w_tgt;
                    end else begin
                        w_pc_nxt = r_pc + w_incr;
                    end
                end else if (i_redirect_valid) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_tgt_nxt = i_redirect_target;
                end
            end
            TRAP: begin
                if (i_trap_clear) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = TRAP_VECTOR;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= 32'd0;
            r_trap_pc  <= 32'd0;
            r_hold     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_trap_pc  <= w_trap_pc_nxt;
            r_hold     <= w_hold_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a behavioural model of the fetch PC rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid, fetch_ready = 1'b0;
    logic [31:0] fetch_pc, pc_plus4, trap_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        stall = 1'b0, misalign_trap, trap_clear = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_fetch_valid(fetch_valid), .i_fetch_ready(fetch_ready),
        .o_fetch_pc(fetch_pc), .o_pc_plus4(pc_plus4),
        .i_redirect_valid(redirect_valid), .i_redirect_target(redirect_target),
        .i_stall(stall), .o_misalign_trap(misalign_trap), .o_trap_pc(trap_pc),
`ifdef PC_SEQ_COMPRESSED_EN
        .i_is_compressed(1'b0),
`endif
        .i_trap_clear(trap_clear)
    );

`ifdef PC_SEQ_COMPRESSED_EN
    localparam int ALIGN = 2;
`else
    localparam int ALIGN = 4;
`endif

    // Model: "starting" means the first cycle after reset release, "trapped" the trap window.
    bit          m_starting, m_trapped, m_offered_unaccepted;
    logic [31:0] m_pc, m_trap_pc;
    logic [31:0] m_pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fv();
        return !m_starting && !m_trapped && (!stall || m_offered_unaccepted);
    endfunction

    task automatic model_reset();
        m_starting = 1; m_trapped = 0; m_offered_unaccepted = 0;
        m_pc = 32'd0; m_trap_pc = 32'd0; m_pend.delete();
    endtask

    task automatic compare_all();
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv()});
        chk("fetch_pc", fetch_pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trapped});
        chk("trap_pc", trap_pc, m_trap_pc);
    endtask

    task automatic model_step();
        bit fv, xfer;
        logic [31:0] tgt;
        bit have;
        fv = m_fv();
        xfer = fv && fetch_ready;
        if (m_starting) begin
            m_starting = 0;
            if (redirect_valid) m_pend = {redirect_target};
        end else if (m_trapped) begin
            if (trap_clear) begin m_trapped = 0; m_pc = 32'h100; end
        end else if (xfer) begin
            have = redirect_valid || (m_pend.size() != 0);
            tgt = redirect_valid ? redirect_target : (m_pend.size() != 0 ? m_pend[0] : 32'd0);
            m_pend.delete();
            if (have && (tgt % ALIGN) != 0) begin
                m_trapped = 1; m_trap_pc = tgt;
            end else if (have) m_pc = tgt;
            else m_pc = m_pc + 32'd4;
        end else if (redirect_valid) begin
            m_pend = {redirect_target};
        end
        m_offered_unaccepted = fv && !fetch_ready && !m_trapped;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit rv, input logic [31:0] tg, input bit rdy, input bit st, input bit clr);
        redirect_valid = rv; redirect_target = tg; fetch_ready = rdy; stall = st; trap_clear = clr;
        #2;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'd0);
        chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
        chk("rst_trap_pc", trap_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("init_fetch_pc", fetch_pc, 32'd0);
        rst_n = 1'b1;

        // Boot cycle then sequential fetch 0, 4, 8.
        cycle(0, 0, 1, 0, 0);
        chk("seq0", fetch_pc, 32'd0);
        cycle(0, 0, 1, 0, 0);
        chk("seq4", fetch_pc, 32'd4);
        cycle(0, 0, 1, 0, 0);
        chk("seq8", fetch_pc, 32'd8);
        cycle(1, 32'd120, 1, 0, 0);
        chk("redir120", fetch_pc, 32'd120);
        cycle(0, 0, 1, 0, 0);
        chk("after124", fetch_pc, 32'd124);
        cycle(0, 0, 1, 0, 0);
        chk("at128", fetch_pc, 32'd128);
        // Redirect lands in the first of three unaccepted cycles.
        cycle(1, 32'd120, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        chk("held128", fetch_pc, 32'd128);
        chk("held_valid", {31'd0, fetch_valid}, 32'd1);
        cycle(0, 0, 1, 0, 0);
        chk("pending120", fetch_pc, 32'd120);
        // Wraparound.
        cycle(1, 32'hFFFF_FFFC, 1, 0, 0);
        chk("at_top", fetch_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 1, 0, 0);
        chk("wrap", fetch_pc, 32'd0);
        chk("wrap_no_trap", {31'd0, misalign_trap}, 32'd0);
        // Misaligned target traps; redirects ignored until cleared.
        cycle(1, 32'd102, 1, 0, 0);
        chk("trap_flag", {31'd0, misalign_trap}, 32'd1);
        chk("trap_pc102", trap_pc, 32'd102);
        cycle(1, 32'd400, 1, 0, 0);
        cycle(0, 0, 1, 0, 1);
        chk("vector", fetch_pc, 32'h100);
        chk("vector_valid", {31'd0, fetch_valid}, 32'd1);
        // Reset while a request is held and a redirect is pending.
        cycle(0, 0, 0, 0, 0);
        cycle(1, 32'd200, 0, 0, 0);
        async_reset();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("post_rst_pc4", fetch_pc, 32'd4);

        for (int i = 0; i < 3000; i++) begin
            bit rv, rdy, st, clr;
            logic [31:0] tg;
            if ($urandom_range(0, 249) == 0) async_reset();
            rv  = ($urandom_range(0, 4) == 0);
            tg  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rdy = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 3) == 0);
            cycle(rv, tg, rdy, st, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
